// File: rtl/vc_flit_sink.sv
// Per-VC flit sink: occupancy tracking, round-robin drain and credit return.
// Optional statistics counters are built when VC_FLIT_SINK_STATS_EN is defined.
module vc_flit_sink #(
  parameter int num_vcs = 4,
  parameter int buffer_size = 8,
  parameter int consume_period = 2,
  parameter int count_width = 32,
  localparam int vc_idx_width = (num_vcs > 1) ? $clog2(num_vcs) : 1,
  localparam int occ_width = $clog2(buffer_size + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flit_valid,
  input  logic                    flit_head,
  input  logic                    flit_tail,
  input  logic [vc_idx_width-1:0] flit_vc,
  input  logic                    stall,
  output logic                    cred_valid,
  output logic [vc_idx_width-1:0] cred_vc,
  output logic                    error,
  output logic [count_width-1:0]  flit_count,
  output logic [count_width-1:0]  packet_count
);

  typedef enum logic {IDLE, BUSY} pkt_state_t;

  localparam logic [7:0] period_last = 8'(consume_period - 1);
  localparam logic [occ_width-1:0] occ_full = occ_width'(buffer_size);

  logic [occ_width-1:0]    occ [num_vcs];
  pkt_state_t              state [num_vcs];
  logic [7:0]              period_cnt;
  logic [vc_idx_width-1:0] last_vc;
  logic [vc_idx_width-1:0] sel_vc;
  logic                    found;
  logic                    opp;
  logic                    drain;
  logic                    overflow;
  logic                    accept;
  logic                    proto_err;

  assign opp = !stall && (period_cnt == period_last);

  // Search starts one past the last-served VC; only registered occupancy counts.
  always_comb begin
    int idx;
    idx = 0;
    found = 1'b0;
    sel_vc = last_vc;
    for (int i = 1; i <= num_vcs; i++) begin
      idx = int'(last_vc) + i;
      if (idx >= num_vcs) idx = idx - num_vcs;
      if (!found && occ[vc_idx_width'(idx)] != '0) begin
        found = 1'b1;
        sel_vc = vc_idx_width'(idx);
      end
    end
  end

  assign drain = opp && found;
  assign overflow = flit_valid && (occ[flit_vc] == occ_full) &&
                    !(drain && sel_vc == flit_vc);
  assign accept = flit_valid && !overflow;
  assign proto_err = flit_valid &&
                     ((state[flit_vc] == BUSY && flit_head) ||
                      (state[flit_vc] == IDLE && !flit_head));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < num_vcs; v++) begin
        occ[v] <= '0;
        state[v] <= IDLE;
      end
      period_cnt <= '0;
      last_vc <= vc_idx_width'(num_vcs - 1);
      cred_valid <= 1'b0;
      cred_vc <= '0;
      error <= 1'b0;
    end else begin
      if (!stall)
        period_cnt <= (period_cnt == period_last) ? 8'd0 : period_cnt + 8'd1;
      for (int v = 0; v < num_vcs; v++) begin
        if (accept && flit_vc == vc_idx_width'(v) &&
            !(drain && sel_vc == vc_idx_width'(v)))
          occ[v] <= occ[v] + 1'b1;
        else if (drain && sel_vc == vc_idx_width'(v) &&
                 !(accept && flit_vc == vc_idx_width'(v)))
          occ[v] <= occ[v] - 1'b1;
      end
      if (flit_valid)
        state[flit_vc] <= flit_tail ? IDLE : BUSY;
      cred_valid <= drain;
      if (drain) begin
        cred_vc <= sel_vc;
        last_vc <= sel_vc;
      end
      if (overflow || proto_err)
        error <= 1'b1;
    end
  end

`ifdef VC_FLIT_SINK_STATS_EN
  logic [count_width-1:0] flit_cnt;
  logic [count_width-1:0] pkt_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flit_cnt <= '0;
      pkt_cnt <= '0;
    end else begin
      if (accept && !(&flit_cnt))
        flit_cnt <= flit_cnt + 1'b1;
      if (accept && flit_tail && !(&pkt_cnt))
        pkt_cnt <= pkt_cnt + 1'b1;
    end
  end

  assign flit_count = flit_cnt;
  assign packet_count = pkt_cnt;
`else
  assign flit_count = '0;
  assign packet_count = '0;
`endif

endmodule

// File: tb/tb_vc_flit_sink.sv
// Testbench for vc_flit_sink: vector table plus credit scoreboard sequences.
module tb_vc_flit_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic        flit_valid;
  logic        flit_head;
  logic        flit_tail;
  logic [1:0]  flit_vc;
  logic        stall;
  logic        cred_valid;
  logic [1:0]  cred_vc;
  logic        error;
  logic [31:0] flit_count;
  logic [31:0] packet_count;

`ifdef VC_FLIT_SINK_STATS_EN
  localparam int stats = 1;
`else
  localparam int stats = 0;
`endif

  always #5 clk = ~clk;

  vc_flit_sink dut (
    .clk(clk),
    .reset(reset),
    .flit_valid(flit_valid),
    .flit_head(flit_head),
    .flit_tail(flit_tail),
    .flit_vc(flit_vc),
    .stall(stall),
    .cred_valid(cred_valid),
    .cred_vc(cred_vc),
    .error(error),
    .flit_count(flit_count),
    .packet_count(packet_count)
  );

  typedef struct {
    logic       v;
    logic       h;
    logic       t;
    logic [1:0] vc;
    logic       st;
    logic       ecv;
    logic [1:0] ecvc;
    logic       eerr;
  } vec_t;

  vec_t       tbl [11];
  int         n_checks = 0;
  int         n_fail = 0;
  bit         sb_on = 1'b0;
  logic [1:0] sb_q [$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [1:0] e;
    if (sb_on && cred_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got credit vc=%0d expected none", cred_vc);
      end else begin
        e = sb_q.pop_front();
        check("sb_cred_vc", 64'(cred_vc), 64'(e));
      end
    end
  end

  task automatic drive(input logic v, input logic h, input logic t,
                       input logic [1:0] vc, input logic st);
    flit_valid = v;
    flit_head = h;
    flit_tail = t;
    flit_vc = vc;
    stall = st;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sb_on = 1'b0;
    sb_q.delete();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sb_on = 1'b1;
  endtask

  task automatic drain_check(input string name, input int budget);
    drive(0, 0, 0, 0, 0);
    repeat (budget) step();
    check(name, 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    //        v  h  t  vc st  cv cvc err
    tbl[0]  = '{1, 1, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 1, 1, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 1, 2, 0, 1, 0, 0};
    tbl[3]  = '{1, 1, 1, 3, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 1, 1, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 1, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 1, 2, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 2, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 1, 3, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 3, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 3, 0};

    // round-robin credit order across all four VCs
    do_reset();
    sb_on = 1'b0;
    check("rst_flit_count", 64'(flit_count), 64'd0);
    check("rst_packet_count", 64'(packet_count), 64'd0);
    for (int i = 0; i < 11; i++) begin
      check($sformatf("tbl%0d_cred_valid", i), 64'(cred_valid), 64'(tbl[i].ecv));
      check($sformatf("tbl%0d_cred_vc", i), 64'(cred_vc), 64'(tbl[i].ecvc));
      check($sformatf("tbl%0d_error", i), 64'(error), 64'(tbl[i].eerr));
      drive(tbl[i].v, tbl[i].h, tbl[i].t, tbl[i].vc, tbl[i].st);
      step();
    end
    check("tbl_flit_count", 64'(flit_count), 64'(4 * stats));
    check("tbl_packet_count", 64'(packet_count), 64'(4 * stats));

    // single head+tail flit on VC2
    do_reset();
    drive(1, 1, 1, 2, 0);
    sb_q.push_back(2'd2);
    step();
    drive(0, 0, 0, 0, 0);
    check("single_c1_cred_valid", 64'(cred_valid), 64'd0);
    step();
    check("single_c2_cred_valid", 64'(cred_valid), 64'd1);
    check("single_c2_cred_vc", 64'(cred_vc), 64'd2);
    check("single_error", 64'(error), 64'd0);
    check("single_packet_count", 64'(packet_count), 64'(stats));
    drain_check("single_sb_empty", 6);

    // overflow VC1 while stalled
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1, 1, 1, 1, 1);
      step();
      if (i == 7) check("ovf_error_after8", 64'(error), 64'd0);
    end
    check("ovf_error_after9", 64'(error), 64'd1);
    check("ovf_flit_count", 64'(flit_count), 64'(8 * stats));
    check("ovf_packet_count", 64'(packet_count), 64'(8 * stats));
    for (int i = 0; i < 8; i++) sb_q.push_back(2'd1);
    drain_check("ovf_sb_empty", 24);
    check("ovf_error_sticky", 64'(error), 64'd1);

    // second head before tail on VC0
    do_reset();
    drive(1, 1, 0, 0, 0);
    sb_q.push_back(2'd0);
    step();
    check("proto_error_c1", 64'(error), 64'd0);
    drive(1, 1, 0, 0, 0);
    sb_q.push_back(2'd0);
    step();
    check("proto_error_c2", 64'(error), 64'd1);
    drive(1, 0, 1, 0, 0);
    sb_q.push_back(2'd0);
    step();
    check("proto_error_c3", 64'(error), 64'd1);
    drain_check("proto_sb_empty", 10);
    check("proto_error_sticky", 64'(error), 64'd1);

    // arrival on a full VC3 in the cycle it is drained
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 1, 3, 1);
      sb_q.push_back(2'd3);
      step();
    end
    drive(0, 0, 0, 0, 0);
    step();
    drive(1, 1, 1, 3, 0);
    sb_q.push_back(2'd3);
    step();
    drive(0, 0, 0, 0, 0);
    check("full_drain_error", 64'(error), 64'd0);
    check("full_drain_cred_valid", 64'(cred_valid), 64'd1);
    check("full_drain_cred_vc", 64'(cred_vc), 64'd3);
    drain_check("full_drain_sb_empty", 24);
    check("full_drain_error_end", 64'(error), 64'd0);

    // asynchronous reset mid-packet
    do_reset();
    drive(1, 0, 0, 1, 1);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1, (i == 0), 0, 0, 1);
      step();
    end
    drive(0, 0, 0, 0, 1);
    check("arst_pre_error", 64'(error), 64'd1);
    check("arst_pre_flit_count", 64'(flit_count), 64'(6 * stats));
    #2;
    reset = 1'b1;
    #1;
    check("arst_cred_valid", 64'(cred_valid), 64'd0);
    check("arst_cred_vc", 64'(cred_vc), 64'd0);
    check("arst_error", 64'(error), 64'd0);
    check("arst_flit_count", 64'(flit_count), 64'd0);
    check("arst_packet_count", 64'(packet_count), 64'd0);
    sb_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1, 1, 1, 0, 0);
    sb_q.push_back(2'd0);
    step();
    drive(0, 0, 0, 0, 0);
    check("arst_head_error", 64'(error), 64'd0);
    drain_check("arst_sb_empty", 8);
    check("arst_error_end", 64'(error), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
